// File: rtl/updown_sweep_ctrl.sv
// updown_sweep_ctrl: triangle-sweep sequencer owning an up/down count
// register with latched bounds, sweep count and endpoint dwell.
module updown_sweep_ctrl #(
  parameter int WIDTH       = 4,
  parameter int SWEEP_W     = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               pause,
  input  logic [WIDTH-1:0]   lo,
  input  logic [WIDTH-1:0]   hi,
  input  logic [SWEEP_W-1:0] n_sweeps,
  output logic [WIDTH-1:0]   count,
  output logic               up_down,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [SWEEP_W-1:0] sweep_cnt
);

  localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TW-1:0] HLAST =
    TW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam bit NOHOLD = (HOLD_CYCLES == 0);

  typedef enum logic [2:0] {
    IDLE, UP, HOLD_HI, DOWN, HOLD_LO, DONE
  } state_t;

  state_t             st, st_n;
  logic [WIDTH-1:0]   lo_q, hi_q, lo_n, hi_n;
  logic [SWEEP_W-1:0] ns_q, ns_n;
  logic [WIDTH-1:0]   cnt_n, dn_step, up_step;
  logic [SWEEP_W-1:0] swp_n, swp_inc;
  logic [TW-1:0]      tmr, tmr_n;
  logic               err_n;

  // Leaving a dwell takes the first step of the new direction at once,
  // so each endpoint shows for exactly 1+HOLD_CYCLES cycles.
  assign dn_step = (count > lo_q) ? count - 1'b1 : count;
  assign up_step = (count < hi_q) ? count + 1'b1 : count;
  assign swp_inc = sweep_cnt + 1'b1;

  always_comb begin
    st_n  = st;
    cnt_n = count;
    swp_n = sweep_cnt;
    tmr_n = tmr;
    lo_n  = lo_q;
    hi_n  = hi_q;
    ns_n  = ns_q;
    err_n = 1'b0;
    if (abort) begin
      st_n = IDLE;
    end else if (!pause) begin
      unique case (st)
        IDLE: begin
          if (start) begin
            if (lo > hi || n_sweeps == '0) begin
              err_n = 1'b1;
            end else begin
              lo_n  = lo;
              hi_n  = hi;
              ns_n  = n_sweeps;
              cnt_n = lo;
              swp_n = '0;
              st_n  = UP;
            end
          end
        end
        UP: begin
          if (count < hi_q) begin
            cnt_n = count + 1'b1;
          end else if (NOHOLD) begin
            st_n  = DOWN;
            cnt_n = dn_step;
          end else begin
            st_n  = HOLD_HI;
            tmr_n = '0;
          end
        end
        HOLD_HI: begin
          if (tmr == HLAST) begin
            st_n  = DOWN;
            cnt_n = dn_step;
          end else begin
            tmr_n = tmr + 1'b1;
          end
        end
        DOWN: begin
          if (count > lo_q) begin
            cnt_n = count - 1'b1;
          end else begin
            swp_n = swp_inc;
            if (swp_inc == ns_q) begin
              st_n = DONE;
            end else if (NOHOLD) begin
              st_n  = UP;
              cnt_n = up_step;
            end else begin
              st_n  = HOLD_LO;
              tmr_n = '0;
            end
          end
        end
        HOLD_LO: begin
          if (tmr == HLAST) begin
            st_n  = UP;
            cnt_n = up_step;
          end else begin
            tmr_n = tmr + 1'b1;
          end
        end
        DONE: st_n = IDLE;
        default: st_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      st        <= IDLE;
      count     <= '0;
      sweep_cnt <= '0;
      tmr       <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      ns_q      <= '0;
      up_down   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      st        <= st_n;
      count     <= cnt_n;
      sweep_cnt <= swp_n;
      tmr       <= tmr_n;
      lo_q      <= lo_n;
      hi_q      <= hi_n;
      ns_q      <= ns_n;
      up_down   <= (st_n == UP) || (st_n == HOLD_HI);
      busy      <= (st_n != IDLE);
      done      <= (st_n == DONE) && (st != DONE);
      err       <= err_n;
    end
  end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// tb_updown_sweep_ctrl: scoreboard bench; expected per-cycle frames
// are queued as stimulus is driven and popped at each falling edge.
module tb_updown_sweep_ctrl;

  localparam int W = 4;
  localparam int SW = 4;
  localparam int H = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start, abort, pause;
  logic [W-1:0]  lo, hi;
  logic [SW-1:0] n_sweeps;
  logic [W-1:0]  count;
  logic          up_down, busy, done, err;
  logic [SW-1:0] sweep_cnt;

  int tests = 0;
  int fails = 0;
  logic [11:0] sb[$];

  always #5 clk = ~clk;

  updown_sweep_ctrl #(
    .WIDTH(W), .SWEEP_W(SW), .HOLD_CYCLES(H)
  ) dut (
    .clk(clk), .reset(reset),
    .start(start), .abort(abort), .pause(pause),
    .lo(lo), .hi(hi), .n_sweeps(n_sweeps),
    .count(count), .up_down(up_down), .busy(busy),
    .done(done), .err(err), .sweep_cnt(sweep_cnt)
  );

  task automatic check(input string tag,
                       input logic [11:0] got,
                       input logic [11:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h (e,d,b,ud,sw,cnt)",
               tag, got, exp);
    end
  endtask

  task automatic push(input int c, input bit ud, input bit b,
                      input bit d, input bit e, input int sw);
    sb.push_back({e, d, b, ud, 4'(sw), 4'(c)});
  endtask

  task automatic step(input string tag);
    logic [11:0] x;
    @(negedge clk);
    x = sb.pop_front();
    check(tag, {err, done, busy, up_down, sweep_cnt, count}, x);
  endtask

  task automatic drain(input string tag);
    while (sb.size() > 0) step(tag);
  endtask

  task automatic kick();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Triangle pattern built from the bounds: ramp up, dwell at hi,
  // ramp down, dwell at lo between sweeps, then DONE and IDLE.
  task automatic gen_run(input int l, input int h, input int n);
    int sw;
    int v0;
    sw = 0;
    for (int s = 0; s < n; s++) begin
      v0 = (s == 0) ? l : ((l < h) ? l + 1 : h);
      for (int v = v0; v <= h; v++) push(v, 1, 1, 0, 0, sw);
      for (int k = 0; k < H; k++) push(h, 1, 1, 0, 0, sw);
      v0 = (h > l) ? h - 1 : l;
      for (int v = v0; v >= l; v--) push(v, 0, 1, 0, 0, sw);
      sw++;
      if (s < n - 1)
        for (int k = 0; k < H; k++) push(l, 0, 1, 0, 0, sw);
    end
    push(l, 0, 1, 1, 0, n);
    push(l, 0, 0, 0, 0, n);
  endtask

  task automatic run(input string tag, input int l,
                     input int h, input int n);
    lo = 4'(l);
    hi = 4'(h);
    n_sweeps = 4'(n);
    gen_run(l, h, n);
    kick();
    lo = 4'($urandom);
    hi = 4'($urandom);
    n_sweeps = 4'($urandom);
    drain(tag);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b1;
    abort = 1'b0;
    pause = 1'b0;
    lo = 4'd2;
    hi = 4'd5;
    n_sweeps = 4'd1;
    repeat (2) @(posedge clk);
    push(0, 0, 0, 0, 0, 0);
    step("reset");
    reset = 1'b1;
    start = 1'b0;
    push(0, 0, 0, 0, 0, 0);
    step("idle");

    run("single", 2, 5, 1);
    run("two_full", 0, 15, 2);

    lo = 4'd6; hi = 4'd3; n_sweeps = 4'd1;
    kick();
    push(0, 0, 0, 0, 1, 2);
    push(0, 0, 0, 0, 0, 2);
    drain("bad_bounds");
    lo = 4'd1; hi = 4'd4; n_sweeps = 4'd0;
    kick();
    push(0, 0, 0, 0, 1, 2);
    push(0, 0, 0, 0, 0, 2);
    drain("zero_n");
    n_sweeps = 4'd1;
    abort = 1'b1;
    kick();
    abort = 1'b0;
    push(0, 0, 0, 0, 0, 2);
    drain("abort_start");

    lo = 4'd1; hi = 4'd9; n_sweeps = 4'd1;
    kick();
    hi = 4'd2;
    for (int v = 1; v <= 4; v++) push(v, 1, 1, 0, 0, 0);
    drain("ctl_ramp");
    pause = 1'b1;
    start = 1'b1;
    for (int k = 0; k < 4; k++) push(4, 1, 1, 0, 0, 0);
    drain("ctl_pause");
    pause = 1'b0;
    start = 1'b0;
    for (int v = 5; v <= 7; v++) push(v, 1, 1, 0, 0, 0);
    drain("ctl_resume");
    abort = 1'b1;
    push(7, 0, 0, 0, 0, 0);
    step("ctl_abort");
    abort = 1'b0;
    for (int k = 0; k < 2; k++) push(7, 0, 0, 0, 0, 0);
    drain("ctl_after");

    run("degen", 3, 3, 1);

    lo = 4'd2; hi = 4'd6; n_sweeps = 4'd3;
    kick();
    push(2, 1, 1, 0, 0, 0);
    push(3, 1, 1, 0, 0, 0);
    drain("mid_run");
    reset = 1'b0;
    push(0, 0, 0, 0, 0, 0);
    step("mid_reset");
    reset = 1'b1;
    push(0, 0, 0, 0, 0, 0);
    step("post_reset");

    run("short", 4, 6, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
